// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK state.
package imem_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_OFFSET     = 512;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        LOAD = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK  = 3'd4,
`endif
        FIN  = 3'd5
    } state_t;

    // Number of words the selected target region can hold.
    function automatic logic [31:0] region_capacity(
        input logic        unified,
        input logic        region_b,
        input int unsigned addr_width,
        input int unsigned offset
    );
        logic [31:0] full_v;
        full_v = 32'd1 << addr_width;
        if (unified) begin
            return full_v;
        end else if (region_b) begin
            return full_v - offset;
        end else begin
            return offset;
        end
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer for the loader (module byte_packer).
// The first byte of a word ends up in bits [7:0]. The completed word is held
// until the next one completes, and word_valid pulses for one cycle after the
// fourth byte. Used by imem_loader with or without IMEM_LOADER_CHECKSUM_EN.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;
    logic [31:0] word_r;
    logic        word_valid_r;

    assign last       = (cnt_r == 2'd3);
    assign word       = word_r;
    assign word_valid = word_valid_r;

    // Shift in bytes; the fourth byte completes and publishes the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r      <= 24'd0;
            cnt_r        <= 2'd0;
            word_r       <= 32'd0;
            word_valid_r <= 1'b0;
        end else if (clr) begin
            shift_r      <= 24'd0;
            cnt_r        <= 2'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            if (in_valid) begin
                cnt_r <= cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    word_r       <= {in_byte, shift_r};
                    word_valid_r <= 1'b1;
                    shift_r      <= 24'd0;
                end else begin
                    shift_r <= {in_byte, shift_r[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit word count followed by
// little-endian words on a byte stream and writes them into the unified
// memory or into split region A/B. Define IMEM_LOADER_CHECKSUM_EN to require
// a trailing 4-byte XOR checksum of the written words.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int OFFSET     = DEFAULT_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  region,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    state_t                state_r, state_s;
    logic                  mode_r, region_r;
    logic [7:0]            len_lo_r;
    logic [15:0]           len_r, len_s, wc_r;
    logic [ADDR_WIDTH-1:0] waddr_r, base_s;
    logic [31:0]           cap_s;
    logic                  s_ready_r, ready_s, busy_r, done_r, error_r;
    logic                  xfer_s, start_acc_s, len_bad_s, last_word_s;
    logic                  pk_last_s, pk_valid_s;
    logic [31:0]           pk_word_s;

    assign xfer_s      = s_valid && s_ready_r;
    assign start_acc_s = start && (state_r == IDLE);
    assign len_s       = {s_data, len_lo_r};
    assign cap_s       = region_capacity(mode_r, region_r, ADDR_WIDTH, OFFSET);
    assign len_bad_s   = ({16'd0, len_s} > cap_s);
    assign base_s      = (!mode_r && region_r) ? ADDR_WIDTH'(OFFSET) : {ADDR_WIDTH{1'b0}};
    assign last_word_s = ((wc_r + 16'd1) == len_r);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc_s),
        .in_valid   (xfer_s && (state_r == LOAD)),
        .in_byte    (s_data),
        .last       (pk_last_s),
        .word       (pk_word_s),
        .word_valid (pk_valid_s)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        ck_last_s, ck_valid_s;
    logic [31:0] ck_word_s, xor_r;

    byte_packer u_ck_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc_s),
        .in_valid   (xfer_s && (state_r == CHK)),
        .in_byte    (s_data),
        .last       (ck_last_s),
        .word       (ck_word_s),
        .word_valid (ck_valid_s)
    );

    // Running XOR of every written word, restarted with each load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_r <= 32'd0;
        end else if (start_acc_s) begin
            xor_r <= 32'd0;
        end else if (pk_valid_s) begin
            xor_r <= xor_r ^ pk_word_s;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and the stream-ready level for the next state.
    always_comb begin
        state_s = state_r;
        ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) state_s = LEN0;
                else       state_s = IDLE;
            end
            LEN0: begin
                if (xfer_s) state_s = LEN1;
                else        state_s = LEN0;
            end
            LEN1: begin
                if (xfer_s && (len_bad_s || (len_s == 16'd0))) state_s = FIN;
                else if (xfer_s)                               state_s = LOAD;
                else                                           state_s = LEN1;
            end
            LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer_s && pk_last_s && last_word_s) state_s = CHK;
                else                                    state_s = LOAD;
`else
                if (xfer_s && pk_last_s && last_word_s) state_s = FIN;
                else                                    state_s = LOAD;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer_s && ck_last_s) state_s = FIN;
                else                     state_s = CHK;
            end
`endif
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
        case (state_s)
            LEN0, LEN1, LOAD: ready_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:              ready_s = 1'b1;
`endif
            default:          ready_s = 1'b0;
        endcase
    end

    // Datapath: length capture, write addressing, status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r    <= 1'b0;
            region_r  <= 1'b0;
            len_lo_r  <= 8'd0;
            len_r     <= 16'd0;
            wc_r      <= 16'd0;
            waddr_r   <= {ADDR_WIDTH{1'b0}};
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            s_ready_r <= ready_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_r == FIN);
            if (start_acc_s) begin
                mode_r   <= mode;
                region_r <= region;
                error_r  <= 1'b0;
                wc_r     <= 16'd0;
            end
            if ((state_r == LEN0) && xfer_s) begin
                len_lo_r <= s_data;
            end
            if ((state_r == LEN1) && xfer_s) begin
                len_r <= len_s;
                if (len_bad_s) error_r <= 1'b1;
            end
            // The address is fixed on the fourth byte so it is ready in the write cycle.
            if ((state_r == LOAD) && xfer_s && pk_last_s) begin
                waddr_r <= base_s + ADDR_WIDTH'(wc_r);
            end
            if (pk_valid_s) begin
                wc_r <= wc_r + 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (ck_valid_s && (ck_word_s != xor_r)) begin
                error_r <= 1'b1;
            end
`endif
        end
    end

    assign s_ready    = s_ready_r;
    assign we         = pk_valid_s;
    assign waddr      = waddr_r;
    assign wdata      = DATA_WIDTH'(pk_word_s);
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = wc_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. Directed loads push expected writes and
// expected completion status into queues; a negedge monitor pops and compares
// whenever the DUT writes or signals done. Covers IMEM_LOADER_CHECKSUM_EN too.
module tb_imem_loader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, mode, region, start, s_valid;
    logic [7:0]    s_data;
    logic          s_ready, we, busy, done, error;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [15:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] wr_q[$];
    logic [16:0]      done_q[$];
    logic [7:0]       stim[$];
    logic             done_prev = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET(512)) dut (
        .clk(clk), .rst(rst), .mode(mode), .region(region), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we(we),
        .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each write and each done pulse against the queues.
    always @(negedge clk) begin
        logic [AW+DW-1:0] wexp;
        logic [16:0]      dexp;
        if (!rst && we) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_we actual waddr=%0h wdata=%0h expected no write", waddr, wdata);
            end else begin
                wexp = wr_q.pop_front();
                chk("waddr", 32'(waddr), 32'(wexp[AW+DW-1:DW]));
                chk("wdata", wdata, wexp[DW-1:0]);
            end
        end
        if (!rst && done) begin
            chk("done_width", 32'(done_prev), 32'd0);
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                dexp = done_q.pop_front();
                chk("done_error", 32'(error), 32'(dexp[16]));
                chk("done_word_count", 32'(word_count), 32'(dexp[15:0]));
            end
        end
        done_prev <= done;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL byte_timeout actual s_ready=0 expected s_ready=1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic start_pulse(input logic m, input logic r);
        @(negedge clk);
        start = 1'b1; mode = m; region = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stim();
        while (stim.size() > 0) send_byte(stim.pop_front());
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual busy=1 expected busy=0");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic add_word(input logic [31:0] w);
        stim.push_back(w[7:0]);   stim.push_back(w[15:8]);
        stim.push_back(w[23:16]); stim.push_back(w[31:24]);
    endtask

    task automatic add_ck(input logic [31:0] w);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add_word(w);
`else
        if (w == 32'd0) stim.push_back(8'd0); // keep arg referenced; never used with zero
        else            stim.delete(stim.size());
`endif
    endtask

    task automatic load(input logic m, input logic r);
        start_pulse(m, r);
        send_stim();
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; region = 1'b0; start = 1'b0;
        s_valid = 1'b0; s_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        // Unified, two words; a stray start mid-load must be ignored.
        wr_q.push_back({10'd0, 32'h12345678});
        wr_q.push_back({10'd1, 32'hDEADBEEF});
        done_q.push_back({1'b0, 16'd2});
        start_pulse(1'b1, 1'b0);
        send_byte(8'h02); send_byte(8'h00);
        start_pulse(1'b0, 1'b1);
        add_word(32'h12345678); add_word(32'hDEADBEEF); add_ck(32'hCC99E897);
        send_stim();
        wait_idle();
        chk("hold_word_count", 32'(word_count), 32'd2);
        chk("hold_waddr", 32'(waddr), 32'd1);
        chk("hold_wdata", wdata, 32'hDEADBEEF);

        // Split B, one word at the region base.
        wr_q.push_back({10'd512, 32'h00000013});
        done_q.push_back({1'b0, 16'd1});
        stim.push_back(8'h01); stim.push_back(8'h00);
        add_word(32'h00000013); add_ck(32'h00000013);
        load(1'b0, 1'b1);

        // Split A, 513 words exceeds capacity 512.
        done_q.push_back({1'b1, 16'd0});
        stim.push_back(8'h01); stim.push_back(8'h02);
        load(1'b0, 1'b0);
        chk("sticky_error", 32'(error), 32'd1);

        // Zero-length load: done exactly two cycles after the LEN1 byte.
        done_q.push_back({1'b0, 16'd0});
        start_pulse(1'b1, 1'b0);
        send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        chk("n0_done_cycle1", 32'(done), 32'd0);
        @(negedge clk);
        chk("n0_done_cycle2", 32'(done), 32'd1);
        wait_idle();

        // Split B, 513 words exceeds capacity 512.
        done_q.push_back({1'b1, 16'd0});
        stim.push_back(8'h01); stim.push_back(8'h02);
        load(1'b0, 1'b1);

        // Unified, 1025 words exceeds capacity 1024.
        done_q.push_back({1'b1, 16'd0});
        stim.push_back(8'h01); stim.push_back(8'h04);
        load(1'b1, 1'b0);

        // Reset in the middle of word 1, then a fresh load from base.
        start_pulse(1'b1, 1'b0);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_q.push_back({10'd0, 32'hAABBCCDD});
        done_q.push_back({1'b0, 16'd1});
        stim.push_back(8'h01); stim.push_back(8'h00);
        add_word(32'hAABBCCDD); add_ck(32'hAABBCCDD);
        load(1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good (1 ^ 3 = 2) then bad (5).
        wr_q.push_back({10'd0, 32'h1}); wr_q.push_back({10'd1, 32'h3});
        done_q.push_back({1'b0, 16'd2});
        stim.push_back(8'h02); stim.push_back(8'h00);
        add_word(32'h1); add_word(32'h3); add_word(32'h2);
        load(1'b1, 1'b0);
        wr_q.push_back({10'd0, 32'h1}); wr_q.push_back({10'd1, 32'h3});
        done_q.push_back({1'b1, 16'd2});
        stim.push_back(8'h02); stim.push_back(8'h00);
        add_word(32'h1); add_word(32'h3); add_word(32'h5);
        load(1'b1, 1'b0);
`endif

        chk("writes_left", 32'(wr_q.size()), 32'd0);
        chk("dones_left", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
